fpu_result_serializer: RTL and testbench
========================================

Name: fpu_result_serializer

Overview:
- Board-side readback path for FPU units (fsqrt and the other FPU blocks) on the FPGA test harness.
- Takes 32-bit results with a valid strobe and buffers them in a small FIFO. The FPU side has no backpressure.
- Emits each result as two 16-bit half-words, high half first, on a valid/ready stream sized for the 16-bit board I/O.
- Width-reducing counterpart of the harness's 16-to-32-bit switch-input deserializer.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of two, at least 2.
- CNT_W, 8, width of the saturating dropped-result counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  32  FPU result word.
- in_valid  in  1  in_data valid this cycle; single-cycle strobe; cannot be stalled.
- out_half  out  16  current half-word.
- out_valid  out  1  out_half valid.
- out_ready  in  1  consumer accepts out_half.
- out_last  out  1  final beat of the current word.
- overflow_cnt  out  CNT_W  results dropped because the FIFO was full; saturating.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: out_valid=0, out_last=0, out_half=0, overflow_cnt=0, busy=0, FIFO empty, FSM IDLE.
- Asserting rst mid-word discards all buffered and in-flight data. out_valid is 0 in the cycle after rst is sampled high.
- FIFO push: in_data is written at the edge where in_valid=1 and (count<DEPTH, or a pop occurs at that same edge).
- FIFO full and no pop at that edge: the word is dropped and overflow_cnt increments, saturating at 2^CNT_W-1.
- Pop occurs only on the final-beat handshake of a word.
- Handshake: a beat transfers at an edge where out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, out_half, out_last and out_valid hold stable.
- FSM states and transitions:
  - IDLE: out_valid=0. Goes to HI when the FIFO is non-empty or a push is accepted this cycle.
  - HI: out_valid=1, out_half=head[31:16], out_last=0. Goes to LO on handshake.
  - LO: out_valid=1, out_half=head[15:0], out_last=1. On handshake, pops the head, then goes to HI if the FIFO still holds a word (including a same-edge push), else to IDLE.
- Latency: in_valid in cycle N into an empty, idle block gives out_valid=1 with the high half in cycle N+1.
- Throughput: one word per two cycles with out_ready held at 1.
- The FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- No combinational path from in_valid to out_valid. out_ready may combinationally affect only the push-accept decision.

Optional Feature:
- FPU_RESULT_CHECKSUM_EN.
- When defined: a third state CHK follows LO.
  - LO has out_last=0 and moves to CHK on handshake; no pop occurs in LO.
  - CHK: out_half = head[31:16] ^ head[15:0], out_last=1. Pop and next-state rules are the same as LO without the macro.
  - Throughput becomes one word per three cycles.
- When undefined: CHK logic is absent and behaviour is exactly as described above.

Decomposition:
- Shared package fpu_io_pkg:
  - HALF_W=16 and WORD_W=32 constants.
  - State typedef ser_state_t {IDLE, HI, LO, CHK}; CHK is always declared and only used under the macro.
  - A function fold16(word) returning the 16-bit XOR fold.
- Sub-module fpu_result_fifo: synchronous FIFO of WORD_W by DEPTH, with push/pop/full/empty/count and a combinational head read.
- The serializer FSM, overflow counter and output mux live in the top.

Test Plan:
- Single word, out_ready=1: push 0x3FB504F3 in cycle 0 -> cycle 1 out_half=0x3FB5 out_last=0; cycle 2 out_half=0x04F3 out_last=1; cycle 3 out_valid=0, busy=0.
- Backpressure: push 0x40490FDB, hold out_ready=0 for 5 cycles -> out_half stays 0x4049 with out_valid=1; release -> 0x4049 then 0x0FDB in order.
- Overflow: DEPTH=4, out_ready=0, push 6 consecutive words -> overflow_cnt=2; drain yields words 1-4 only, 8 beats. Repeat to 300 drops with CNT_W=8 -> overflow_cnt=255.
- Full-plus-pop: FIFO full, out_ready=1 in LO, push 0x11112222 at the popping edge -> word accepted, overflow_cnt unchanged, emitted last.
- Reset mid-word: in HI with 3 words queued, assert rst one cycle -> out_valid=0 next cycle, busy=0. A new push 0x00010002 emits 0x0001, 0x0002 only.
- Checksum (FPU_RESULT_CHECKSUM_EN defined): push 0x3FB504F3 -> beats 0x3FB5, 0x04F3, 0x3B46; out_last only on 0x3B46.

Source files
------------

// File: rtl/fpu_io_pkg.sv
// Shared word/half-word widths, serializer state type and XOR fold helper
// for the FPU board readback path.
package fpu_io_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // CHK is only reachable when FPU_RESULT_CHECKSUM_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    CHK  = 2'd3
  } ser_state_t;

  function automatic logic [HALF_W-1:0] fold16(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:HALF_W] ^ word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous WORD_W x DEPTH FIFO with a combinational head read, so the
// serializer sees the oldest word in the cycle after it is written.
module fpu_result_fifo
  import fpu_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WORD_W-1:0]         push_data,
  input  logic                      pop,
  output logic [WORD_W-1:0]         head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fpu_result_serializer.sv
// Buffers 32-bit FPU results and emits them as 16-bit half-words, high first.
// Define FPU_RESULT_CHECKSUM_EN to append an XOR-fold checksum beat per word.
module fpu_result_serializer
  import fpu_io_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic [15:0]       out_half,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  overflow_cnt,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  ser_state_t        state_q, state_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic [WORD_W-1:0] head;
  logic              full, empty;
  logic [AW:0]       count;
  logic              pop;
  logic              push_acc;
  logic              more_words;

  // The final beat's handshake frees a slot that a same-edge push may reuse.
`ifdef FPU_RESULT_CHECKSUM_EN
  assign pop = (state_q == CHK) && out_ready;
`else
  assign pop = (state_q == LO) && out_ready;
`endif
  assign push_acc   = in_valid && (!full || pop);
  assign more_words = (count > (AW+1)'(1)) || push_acc;

  fpu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_acc),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_half  = '0;
    case (state_q)
      IDLE: begin
        if (!empty || push_acc) state_d = HI;
      end
      HI: begin
        out_valid = 1'b1;
        out_half  = head[WORD_W-1:HALF_W];
        if (out_ready) state_d = LO;
      end
      LO: begin
        out_valid = 1'b1;
        out_half  = head[HALF_W-1:0];
`ifdef FPU_RESULT_CHECKSUM_EN
        if (out_ready) state_d = CHK;
`else
        out_last  = 1'b1;
        if (out_ready) state_d = more_words ? HI : IDLE;
`endif
      end
      CHK: begin
`ifdef FPU_RESULT_CHECKSUM_EN
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_half  = fold16(head);
        if (out_ready) state_d = more_words ? HI : IDLE;
`else
        state_d   = IDLE;
`endif
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && !push_acc && (ovf_q != '1)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_cnt = ovf_q;
  assign busy         = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_result_serializer.sv
// Randomized and directed bench for fpu_result_serializer against a queue-based
// model of word buffering and beat emission.
module tb_fpu_result_serializer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef FPU_RESULT_CHECKSUM_EN
  localparam int BEATS = 3;
`else
  localparam int BEATS = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic [15:0]       out_half;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic [CNT_W-1:0]  overflow_cnt;
  logic              busy;

  fpu_result_serializer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_half     (out_half),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overflow_cnt (overflow_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: words held (head first), whether a word is being emitted, beat index.
  logic [31:0] mq[$];
  bit          m_act = 0;
  int          m_beat = 0;
  int          m_ovf = 0;
  bit          started = 0;
  logic [15:0] beat_log[$];

  function automatic logic [15:0] exp_half(input logic [31:0] w, input int b);
    if (b == 0) return w[31:16];
    if (b == 1) return w[15:0];
    return w[31:16] ^ w[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_act});
    chk("overflow_cnt", {{(32-CNT_W){1'b0}}, overflow_cnt}, m_ovf);
    chk("busy", {31'd0, busy}, {31'd0, (mq.size() > 0) || m_act});
    if (m_act) begin
      chk("out_half", {16'd0, out_half}, {16'd0, exp_half(mq[0], m_beat)});
      chk("out_last", {31'd0, out_last}, {31'd0, m_beat == BEATS-1});
    end
  endtask

  task automatic model_step();
    bit hs, pop, was_full;
    if (rst) begin
      mq.delete();
      m_act = 0;
      m_beat = 0;
      m_ovf = 0;
      started = 1;
      return;
    end
    hs = m_act && out_ready;
    pop = hs && (m_beat == BEATS-1);
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (in_valid) begin
      if (!was_full || pop) mq.push_back(in_data);
      else if (m_ovf < SAT) m_ovf++;
    end
    if (!m_act) begin
      m_act = (mq.size() > 0);
      m_beat = 0;
    end else if (hs) begin
      if (m_beat == BEATS-1) begin
        m_beat = 0;
        m_act = (mq.size() > 0);
      end else begin
        m_beat++;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy, input logic r);
    @(negedge clk);
    if (started) compare_outputs();
    in_valid = v;
    in_data = d;
    out_ready = rdy;
    rst = r;
    if (!r && started && out_valid && rdy) beat_log.push_back(out_half);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_last", {31'd0, out_last}, 32'd0);
    chk("reset out_half", {16'd0, out_half}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ovf", {24'd0, overflow_cnt}, 32'd0);

    // Single word with consumer always ready.
    beat_log.delete();
    cycle(1'b1, 32'h3FB504F3, 1'b1, 1'b0);
    chk("lat1 out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat1 out_half", {16'd0, out_half}, 32'h3FB5);
    idle_cycles(BEATS + 1, 1'b1);
    chk("single beats", beat_log.size(), BEATS);
    chk("single hi", {16'd0, beat_log[0]}, 32'h3FB5);
    chk("single lo", {16'd0, beat_log[1]}, 32'h04F3);
`ifdef FPU_RESULT_CHECKSUM_EN
    chk("single chk", {16'd0, beat_log[2]}, 32'h3B46);
`endif
    chk("single busy", {31'd0, busy}, 32'd0);

    // Backpressure holds the high half.
    beat_log.delete();
    cycle(1'b1, 32'h40490FDB, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    chk("bp hold half", {16'd0, out_half}, 32'h4049);
    chk("bp hold valid", {31'd0, out_valid}, 32'd1);
    idle_cycles(BEATS + 2, 1'b1);
    chk("bp beats", beat_log.size(), BEATS);
    chk("bp hi", {16'd0, beat_log[0]}, 32'h4049);
    chk("bp lo", {16'd0, beat_log[1]}, 32'h0FDB);

    // Overflow: six pushes into a stalled depth-4 FIFO.
    beat_log.delete();
    for (int i = 1; i <= 6; i++) cycle(1'b1, {16'(i), 16'(i + 16'h100)}, 1'b0, 1'b0);
    chk("ovf two", {24'd0, overflow_cnt}, 32'd2);
    idle_cycles(4 * BEATS + 2, 1'b1);
    chk("ovf drain beats", beat_log.size(), 4 * BEATS);
    chk("ovf first", {16'd0, beat_log[0]}, 32'h0001);
    chk("ovf fourth", {16'd0, beat_log[3 * BEATS]}, 32'h0004);
    for (int i = 0; i < 302; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("ovf saturate", {24'd0, overflow_cnt}, 32'd255);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Full FIFO with a push on the popping edge.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0A0_0000 + i, 1'b0, 1'b0);
    beat_log.delete();
    idle_cycles(BEATS - 1, 1'b1);
    cycle(1'b1, 32'h11112222, 1'b1, 1'b0);
    chk("fpp ovf", {24'd0, overflow_cnt}, 32'd0);
    idle_cycles(4 * BEATS + 2, 1'b1);
    chk("fpp beats", beat_log.size(), 5 * BEATS);
    chk("fpp last hi", {16'd0, beat_log[4 * BEATS]}, 32'h1111);
    chk("fpp last lo", {16'd0, beat_log[4 * BEATS + 1]}, 32'h2222);

    // Reset in the middle of a word.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5555_0000 + i, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    beat_log.delete();
    cycle(1'b1, 32'h00010002, 1'b1, 1'b0);
    idle_cycles(BEATS + 2, 1'b1);
    chk("rst beats", beat_log.size(), BEATS);
    chk("rst hi", {16'd0, beat_log[0]}, 32'h0001);
    chk("rst lo", {16'd0, beat_log[1]}, 32'h0002);

    // Random traffic with stall phases and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic v, rdy, r;
      v = ($urandom_range(0, 2) != 0);
      rdy = ((i / 100) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 399) == 0);
      cycle(v, $urandom, rdy, r);
    end
    idle_cycles(DEPTH * BEATS + 4, 1'b1);
    chk("final busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
